prio_seg_scan: RTL and testbench
================================

// Module: prio_seg_scan
// PURPOSE
//  Parametrised priority-encoder-to-7-segment display with sequential behaviour.
//  - Takes N_IN active-low request lines and encodes the highest index asserted.
//  - Debounces the encoded code and captures each accepted press into a DIGITS-deep history.
//  - Shows the history on a time-multiplexed common-cathode display, newest code on digit 0.
//  - Sits between the front-panel switches and the display pins in the combinational-lab top levels.
// PARAMETERS
//  N_IN     8     request inputs, 2..16; code width CW=$clog2(N_IN), max 4
//  DIGITS   4     display digits / history depth, 1..8
//  DEB_CYC  16    consecutive stable cycles required for press and for release, >=2
//  SCAN_DIV 1000  clk cycles per digit slot, >=1
// PORTS
//  clk    in   1       system clock, rising edge
//  rst    in   1       asynchronous, active-high reset
//  EI     in   1       active-low encoder enable (1 = no request accepted)
//  I      in   N_IN    active-low request lines; I[N_IN-1] has highest priority
//  clr    in   1       synchronous clear of the history, active-high
//  seg    out  7       {g,f,e,d,c,b,a}, active-high, registered
//  an     out  DIGITS  one-hot digit enable, active-high, registered
//  code   out  4       last captured code, zero-extended
//  valid  out  1       one-cycle pulse per capture
// BEHAVIOUR
//  - Reset: seg=0, an=0, code=0, valid=0, history empty, scan index=0, divider=0, FSM=IDLE.
//  - Sync: I and EI pass through 2-flop synchronisers; all logic uses the synced copies.
//  - Encoder: gs=1 when EI_s==0 and any I_s bit is 0; raw = highest low index. Otherwise gs=0.
//  - FSM (cnt saturates at DEB_CYC-1):
//    - IDLE: gs -> ARM, cnt=0.
//    - ARM: !gs -> IDLE. raw differs from the value latched on entry -> restart, cnt=0.
//      cnt==DEB_CYC-1 -> capture, go to HELD.
//    - HELD: !gs -> REL, cnt=0. Raw changes are ignored; no second capture before release.
//    - REL: gs -> HELD. cnt==DEB_CYC-1 -> IDLE.
//  - Capture:
//    - hist[0]<=raw; hist[k]<=hist[k-1]; occ[0]<=1; occ[k]<=occ[k-1]; oldest entry is dropped.
//    - code<=raw; valid=1 for exactly the next cycle.
//  - Latency: with I held from clock edge t, valid is high in the cycle after edge t+DEB_CYC+3.
//  - clr: occ<=0, code<=0. If clr and capture fall in the same cycle, clr wins: nothing is stored
//    and valid stays 0. FSM still moves to HELD.
//  - Scan:
//    - The divider counts 0..SCAN_DIV-1. At terminal count, idx <= (idx==DIGITS-1) ? 0 : idx+1.
//    - Each cycle: an <= onehot(idx); seg <= occ[idx] ? dec(hist[idx]) : 7'h00.
//    - The new digit appears one cycle after idx changes. With DIGITS==1, an==1 at every cycle after reset.
//  - dec, 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F (6 and 9 drawn with tails).
//  - Reset mid-debounce or mid-scan aborts immediately to the reset values; no capture occurs.
//  - Codes wider than CW never occur; upper code bits read 0.
// CONFIGURATION
//  SEG_HEX_EN defined:   codes 10..15 decode to A b C d E F = 77 7C 39 5E 79 71.
//  SEG_HEX_EN undefined: codes 10..15 decode to 7'h00 (blank, BCD-only decoder behaviour).
//  All other behaviour is identical in both builds.
// TESTING (N_IN=8, DIGITS=4, DEB_CYC=4, SCAN_DIV=2 unless stated)
//  1. rst pulse mid-operation -> all outputs 0 asynchronously. After release, an walks 1,2,4,8,1 every 2 cycles; seg=00 throughout.
//  2. EI=0, I=8'b1101_0111 held 20 cycles -> one valid pulse at edge t+7, code=5, digit 0 shows 6D. Releasing and re-pressing the same input -> second capture.
//  3. EI=0, I=8'b0111_1111 held 3 cycles, then glitching every 2 cycles -> no valid. EI=1 with any I -> no valid.
//  4. Press 1, 2, 3, 4, 5 in turn, each with full debounce -> digits 0..3 show 5,4,3,2 (6D 66 4F 5B); code 1 is dropped.
//  5. clr asserted in the capture cycle -> valid=0, code=0, all digits blank. A later press 7 -> digit 0 shows 07.
//  6. N_IN=16, press I[12] -> code=12; digit 0 shows 39 with SEG_HEX_EN, 00 without.

Source files
------------

// File: rtl/prio_seg_scan.sv
// Active-low priority encoder with debounced capture into a history shown on a
// multiplexed 7-segment display. Define SEG_HEX_EN to decode codes 10..15 as A..F.
module prio_seg_scan #(
    parameter int unsigned N_IN     = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned DEB_CYC  = 16,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EI,
    input  logic [N_IN-1:0]   I,
    input  logic              clr,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic [3:0]        code,
    output logic              valid
);

    localparam int unsigned CNTW = $clog2(DEB_CYC);
    localparam int unsigned DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEB_CYC - 1);
    localparam logic [DIVW-1:0] DIV_MAX = DIVW'(SCAN_DIV - 1);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    logic              ei_m_q, ei_s_q;
    logic [N_IN-1:0]   i_m_q, i_s_q;
    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        hist_q [DIGITS];
    logic [3:0]        hist_d [DIGITS];
    logic [DIGITS-1:0] occ_q, occ_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              gs, capture;
    logic [3:0]        raw;

    function automatic logic [6:0] dec(input logic [3:0] c);
        case (c)
            4'd0: dec = 7'h3F;
            4'd1: dec = 7'h06;
            4'd2: dec = 7'h5B;
            4'd3: dec = 7'h4F;
            4'd4: dec = 7'h66;
            4'd5: dec = 7'h6D;
            4'd6: dec = 7'h7D;
            4'd7: dec = 7'h07;
            4'd8: dec = 7'h7F;
            4'd9: dec = 7'h6F;
`ifdef SEG_HEX_EN
            4'd10: dec = 7'h77;
            4'd11: dec = 7'h7C;
            4'd12: dec = 7'h39;
            4'd13: dec = 7'h5E;
            4'd14: dec = 7'h79;
            4'd15: dec = 7'h71;
`endif
            default: dec = 7'h00;
        endcase
    endfunction

    // Ascending scan so the highest asserted index overwrites lower ones.
    always_comb begin
        raw = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (!i_s_q[k]) raw = 4'(k);
        end
        gs = !ei_s_q && (i_s_q != '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ei_m_q  <= 1'b1;
            ei_s_q  <= 1'b1;
            i_m_q   <= '1;
            i_s_q   <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            ei_m_q  <= EI;
            ei_s_q  <= ei_m_q;
            i_m_q   <= I;
            i_s_q   <= i_m_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: if (gs) begin
                state_d = ARM;
                cnt_d   = '0;
                lat_d   = raw;
            end
            ARM: begin
                if (!gs) begin
                    state_d = IDLE;
                end else if (raw != lat_q) begin
                    lat_d = raw;
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            HELD: if (!gs) begin
                state_d = REL;
                cnt_d   = '0;
            end
            REL: begin
                if (gs) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture = (state_q == ARM) && gs && (raw == lat_q) && (cnt_q == CNT_MAX);
    end

    always_comb begin
        hist_d  = hist_q;
        occ_d   = occ_q;
        code_d  = code_q;
        valid_d = 1'b0;
        // clr takes precedence over a coincident capture.
        if (clr) begin
            occ_d  = '0;
            code_d = '0;
        end else if (capture) begin
            hist_d[0] = raw;
            occ_d[0]  = 1'b1;
            for (int unsigned k = 1; k < DIGITS; k++) begin
                hist_d[k] = hist_q[k-1];
                occ_d[k]  = occ_q[k-1];
            end
            code_d  = raw;
            valid_d = 1'b1;
        end

        div_d = div_q + DIVW'(1);
        idx_d = idx_q;
        if (div_q == DIV_MAX) begin
            div_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDXW'(1);
        end
        an_d  = DIGITS'(1) << idx_q;
        seg_d = occ_q[idx_q] ? dec(hist_q[idx_q]) : 7'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '{default: '0};
            occ_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= '0;
            seg_q   <= '0;
        end else begin
            hist_q  <= hist_d;
            occ_q   <= occ_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign code  = code_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_prio_seg_scan.sv
// Directed self-checking bench for prio_seg_scan (N_IN=8/16, DIGITS=4, DEB_CYC=4, SCAN_DIV=2).
module tb_prio_seg_scan;

    logic        clk = 1'b0;
    logic        rst, EI, clr;
    logic [7:0]  I;
    logic [15:0] I16;
    logic [6:0]  seg, seg16;
    logic [3:0]  an, an16;
    logic [3:0]  code, code16;
    logic        valid, valid16;

    int vectors = 0;
    int errors  = 0;
    logic [6:0] obs [4];

`ifdef SEG_HEX_EN
    localparam logic [6:0] SEG12 = 7'h39;
`else
    localparam logic [6:0] SEG12 = 7'h00;
`endif

    always #5 clk = ~clk;

    prio_seg_scan #(.N_IN(8), .DIGITS(4), .DEB_CYC(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .EI(EI), .I(I), .clr(clr),
        .seg(seg), .an(an), .code(code), .valid(valid)
    );

    prio_seg_scan #(.N_IN(16), .DIGITS(4), .DEB_CYC(4), .SCAN_DIV(2)) dut16 (
        .clk(clk), .rst(rst), .EI(EI), .I(I16), .clr(clr),
        .seg(seg16), .an(an16), .code(code16), .valid(valid16)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Records the segment pattern seen while each digit is enabled.
    task automatic collect_digits;
        for (int d = 0; d < 4; d++) obs[d] = 7'h55;
        repeat (20) begin
            step(1);
            for (int unsigned d = 0; d < 4; d++)
                if (an == 4'(1 << d)) obs[d] = seg;
        end
    endtask

    task automatic press(input int b, output bit got, output logic [3:0] c);
        got = 1'b0;
        c   = 4'hx;
        I = '1;
        I[b] = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1);
            if (valid === 1'b1) begin
                got = 1'b1;
                c   = code;
            end
        end
        I = '1;
        step(12);
    endtask

    task automatic test_reset;
        logic [3:0] exp_an [9] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1};
        step(2);
        vectors++; if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h expected 00", seg); end
        vectors++; if (an !== 4'h0) begin errors++; $display("FAIL reset_an: got %h expected 0", an); end
        vectors++; if (code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", code); end
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step(1);
            vectors++; if (an !== exp_an[k]) begin errors++; $display("FAIL walk_an[%0d]: got %h expected %h", k, an, exp_an[k]); end
            vectors++; if (seg !== 7'h00) begin errors++; $display("FAIL walk_seg[%0d]: got %h expected 00", k, seg); end
        end
    endtask

    task automatic test_press;
        int  pulses;
        bit  got;
        logic [3:0] c;
        I = 8'b1101_0111;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (k == 7) begin
                vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL press_valid_k7: got %b expected 1", valid); end
                vectors++; if (code !== 4'd5) begin errors++; $display("FAIL press_code: got %h expected 5", code); end
            end else begin
                vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL press_valid_k%0d: got %b expected 0", k, valid); end
            end
        end
        collect_digits();
        vectors++; if (obs[0] !== 7'h6D) begin errors++; $display("FAIL press_digit0: got %h expected 6d", obs[0]); end
        for (int d = 1; d < 4; d++) begin
            vectors++; if (obs[d] !== 7'h00) begin errors++; $display("FAIL press_digit%0d: got %h expected 00", d, obs[d]); end
        end
        I = '1;
        step(12);
        pulses = 0;
        I = 8'b1101_0111;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (valid === 1'b1) pulses++;
        end
        vectors++; if (pulses != 1) begin errors++; $display("FAIL repress_pulses: got %0d expected 1", pulses); end
        vectors++; if (code !== 4'd5) begin errors++; $display("FAIL repress_code: got %h expected 5", code); end
        I = '1;
        step(12);
        got = 1'b0; c = '0;
    endtask

    task automatic test_async_reset;
        int pulses;
        I = 8'b1111_1011;
        step(4);
        #2 rst = 1'b1;
        #1;
        vectors++; if (seg !== 7'h00) begin errors++; $display("FAIL arst_seg: got %h expected 00", seg); end
        vectors++; if (an !== 4'h0) begin errors++; $display("FAIL arst_an: got %h expected 0", an); end
        vectors++; if (code !== 4'h0) begin errors++; $display("FAIL arst_code: got %h expected 0", code); end
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", valid); end
        I = '1;
        step(3);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (valid === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin errors++; $display("FAIL arst_pulses: got %0d expected 0", pulses); end
        collect_digits();
        for (int d = 0; d < 4; d++) begin
            vectors++; if (obs[d] !== 7'h00) begin errors++; $display("FAIL arst_digit%0d: got %h expected 00", d, obs[d]); end
        end
    endtask

    task automatic test_glitch;
        int pulses = 0;
        for (int c = 0; c < 27; c++) begin
            if (c < 3) I = 8'b0111_1111;
            else I = (((c - 3) / 2) % 2 == 0) ? 8'hFF : 8'b0111_1111;
            step(1);
            if (valid === 1'b1) pulses++;
        end
        I = '1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (valid === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
        pulses = 0;
        EI = 1'b1;
        I  = 8'h00;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (valid === 1'b1) pulses++;
        end
        vectors++; if (pulses != 0) begin errors++; $display("FAIL ei_pulses: got %0d expected 0", pulses); end
        vectors++; if (code !== 4'h0) begin errors++; $display("FAIL ei_code: got %h expected 0", code); end
        I = '1;
        step(4);
        EI = 1'b0;
        step(4);
    endtask

    task automatic test_history;
        logic [6:0] exp_seg [4] = '{7'h6D, 7'h66, 7'h4F, 7'h5B};
        bit got;
        logic [3:0] c;
        for (int b = 1; b <= 5; b++) begin
            press(b, got, c);
            vectors++; if (!got) begin errors++; $display("FAIL hist_press%0d: got no valid expected pulse", b); end
            vectors++; if (c !== 4'(b)) begin errors++; $display("FAIL hist_code%0d: got %h expected %0d", b, c, b); end
        end
        collect_digits();
        for (int d = 0; d < 4; d++) begin
            vectors++; if (obs[d] !== exp_seg[d]) begin errors++; $display("FAIL hist_digit%0d: got %h expected %h", d, obs[d], exp_seg[d]); end
        end
    endtask

    task automatic test_clr;
        bit got;
        logic [3:0] c;
        I = 8'b1011_1111;
        step(6);
        clr = 1'b1;
        step(1);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", valid); end
        vectors++; if (code !== 4'h0) begin errors++; $display("FAIL clr_code: got %h expected 0", code); end
        clr = 1'b0;
        step(1);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_valid_next: got %b expected 0", valid); end
        collect_digits();
        for (int d = 0; d < 4; d++) begin
            vectors++; if (obs[d] !== 7'h00) begin errors++; $display("FAIL clr_digit%0d: got %h expected 00", d, obs[d]); end
        end
        I = '1;
        step(12);
        press(7, got, c);
        vectors++; if (!got) begin errors++; $display("FAIL clr_press7: got no valid expected pulse"); end
        vectors++; if (c !== 4'd7) begin errors++; $display("FAIL clr_code7: got %h expected 7", c); end
        collect_digits();
        vectors++; if (obs[0] !== 7'h07) begin errors++; $display("FAIL clr_digit0_after: got %h expected 07", obs[0]); end
        for (int d = 1; d < 4; d++) begin
            vectors++; if (obs[d] !== 7'h00) begin errors++; $display("FAIL clr_digit%0d_after: got %h expected 00", d, obs[d]); end
        end
    endtask

    task automatic test_wide;
        bit got = 1'b0;
        bit seen = 1'b0;
        logic [3:0] c = 4'hx;
        logic [6:0] s = 7'h55;
        I16 = 16'hEFFF;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1);
            if (valid16 === 1'b1) begin got = 1'b1; c = code16; end
        end
        vectors++; if (!got) begin errors++; $display("FAIL wide_valid: got no valid expected pulse"); end
        vectors++; if (c !== 4'd12) begin errors++; $display("FAIL wide_code: got %h expected c", c); end
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1);
            if (an16 === 4'd1) begin seen = 1'b1; s = seg16; end
        end
        vectors++; if (s !== SEG12) begin errors++; $display("FAIL wide_digit0: got %h expected %h", s, SEG12); end
        I16 = '1;
        step(12);
        got = 1'b0;
        c = 4'hx;
        I16 = 16'h6FFF;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1);
            if (valid16 === 1'b1) begin got = 1'b1; c = code16; end
        end
        vectors++; if (c !== 4'd15) begin errors++; $display("FAIL wide_prio: got %h expected f", c); end
        I16 = '1;
        step(12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        EI  = 1'b0;
        clr = 1'b0;
        I   = '1;
        I16 = '1;
        test_reset();
        test_press();
        test_async_reset();
        test_glitch();
        test_history();
        test_clr();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
